// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, data-SRAM response tracking with discard of
// responses owed to flushed instructions, and the registered MEM/WB bundle.
//
// state | meaning
// IDLE  | no data_ok owed for the instruction held in MEM
// WAIT  | data_ok owed for the instruction held in MEM
// HAVE  | response captured in rdata_buf, waiting for WB to accept

module mem_stage #(
    parameter int DISCARD_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        mem_in_ready,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_result,
    input  logic [7:0]  ex_mem_op,
    input  logic        ex_res_from_mem,
    input  logic        ex_gr_we,
    input  logic [4:0]  ex_dest,
    input  logic        ex_mem_req,
    input  logic        ex_has_exception,
    input  logic [5:0]  ex_ecode,
    input  logic [8:0]  ex_esubcode,
    input  logic [31:0] ex_maddr,
    input  logic        ex_ertn,
    input  logic        ex_rdcntid,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_in_ready,
    input  logic        flush,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_result,
    output logic [31:0] wb_maddr,
    output logic [7:0]  wb_mem_op,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [4:0]  wb_dest,
    output logic        wb_res_from_mem,
    output logic        wb_gr_we,
    output logic        wb_has_exception,
    output logic        wb_ertn,
    output logic        wb_rdcntid,
    output logic [31:0] wb_rdata,
    output logic        mem_except_block,
    output logic        mem_fwd_we,
    output logic [4:0]  mem_fwd_dest,
    output logic [31:0] mem_fwd_data,
    output logic        mem_load_pending
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HAVE = 2'd2} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] maddr;
        logic [7:0]  mem_op;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [4:0]  dest;
        logic        res_from_mem;
        logic        gr_we;
        logic        has_exception;
        logic        ertn;
        logic        rdcntid;
    } bundle_t;

    localparam logic [DISCARD_W:0] DISCARD_MAX = (DISCARD_W+1)'(2);

    bundle_t                ex_b;
    bundle_t                m_q, m_d, wb_q, wb_d;
    logic                   m_valid_q, m_valid_d;
    logic                   wb_valid_q, wb_valid_d;
    state_t                 state_q, state_d;
    logic [DISCARD_W-1:0]   disc_q, disc_d;
    logic [DISCARD_W:0]     disc_sum;
    logic [31:0]            rdata_buf_q, rdata_buf_d;
    logic [31:0]            wb_rdata_q, wb_rdata_d;
    logic                   ready_go, resp_for_me, move_out, accept;
    logic                   add_wait, add_ex;

    assign ex_b = '{pc: ex_pc, result: ex_result, maddr: ex_maddr, mem_op: ex_mem_op,
                    ecode: ex_ecode, esubcode: ex_esubcode, dest: ex_dest,
                    res_from_mem: ex_res_from_mem, gr_we: ex_gr_we,
                    has_exception: ex_has_exception, ertn: ex_ertn, rdcntid: ex_rdcntid};

    always_comb begin
        ready_go    = 1'b1;
        resp_for_me = 1'b0;
        if (state_q == S_WAIT) begin
            resp_for_me = data_sram_data_ok && (disc_q == '0);
            ready_go    = resp_for_me;
        end
        move_out     = m_valid_q && ready_go && wb_in_ready;
        mem_in_ready = rst && (!m_valid_q || move_out);
        accept       = ex_valid && mem_in_ready && !flush;
    end

    always_comb begin
        m_valid_d   = m_valid_q;
        m_d         = m_q;
        state_d     = state_q;
        disc_d      = disc_q;
        disc_sum    = '0;
        rdata_buf_d = rdata_buf_q;
        wb_valid_d  = wb_valid_q;
        wb_d        = wb_q;
        wb_rdata_d  = wb_rdata_q;
        add_wait    = m_valid_q && (state_q == S_WAIT);
        add_ex      = ex_valid && ex_mem_req;

        if (flush) begin
            m_valid_d  = 1'b0;
            state_d    = S_IDLE;
            wb_valid_d = 1'b0;
            // Every response still owed by a killed instruction must be dropped later;
            // a data_ok landing in this same cycle already pays one of them off.
            disc_sum = {1'b0, disc_q} + (DISCARD_W+1)'(add_wait) + (DISCARD_W+1)'(add_ex);
            if (data_sram_data_ok && (disc_sum != '0))
                disc_sum = disc_sum - (DISCARD_W+1)'(1);
            disc_d = (disc_sum > DISCARD_MAX) ? DISCARD_MAX[DISCARD_W-1:0]
                                              : disc_sum[DISCARD_W-1:0];
        end else begin
            if (data_sram_data_ok && (disc_q != '0))
                disc_d = disc_q - DISCARD_W'(1);

            if (move_out) begin
                wb_d       = m_q;
                wb_rdata_d = (state_q == S_WAIT) ? data_sram_rdata : rdata_buf_q;
                wb_valid_d = 1'b1;
            end else if (wb_in_ready) begin
                wb_valid_d = 1'b0;
            end

            if (accept) begin
                m_d       = ex_b;
                m_valid_d = 1'b1;
                state_d   = ex_mem_req ? S_WAIT : S_IDLE;
            end else if (move_out) begin
                m_valid_d = 1'b0;
                state_d   = S_IDLE;
            end else if (resp_for_me) begin
                state_d     = S_HAVE;
                rdata_buf_d = data_sram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid_q   <= 1'b0;
            m_q         <= '0;
            state_q     <= S_IDLE;
            disc_q      <= '0;
            rdata_buf_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_q        <= '0;
            wb_rdata_q  <= '0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_q         <= m_d;
            state_q     <= state_d;
            disc_q      <= disc_d;
            rdata_buf_q <= rdata_buf_d;
            wb_valid_q  <= wb_valid_d;
            wb_q        <= wb_d;
            wb_rdata_q  <= wb_rdata_d;
        end
    end

    assign wb_valid         = wb_valid_q;
    assign wb_pc            = wb_q.pc;
    assign wb_result        = wb_q.result;
    assign wb_maddr         = wb_q.maddr;
    assign wb_mem_op        = wb_q.mem_op;
    assign wb_ecode         = wb_q.ecode;
    assign wb_esubcode      = wb_q.esubcode;
    assign wb_dest          = wb_q.dest;
    assign wb_res_from_mem  = wb_q.res_from_mem;
    assign wb_gr_we         = wb_q.gr_we;
    assign wb_has_exception = wb_q.has_exception;
    assign wb_ertn          = wb_q.ertn;
    assign wb_rdcntid       = wb_q.rdcntid;
    assign wb_rdata         = wb_rdata_q;

    assign mem_fwd_we       = m_valid_q && m_q.gr_we && !m_q.has_exception;
    assign mem_fwd_dest     = m_q.dest;
    assign mem_fwd_data     = m_q.result;
    assign mem_load_pending = m_valid_q && m_q.res_from_mem && (state_q != S_HAVE) && !resp_for_me;
    assign mem_except_block = (m_valid_q && (m_q.has_exception || m_q.ertn)) ||
                              (wb_valid_q && (wb_q.has_exception || wb_q.ertn));

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table for forwarding/block outputs, directed load/flush/reset
// sequences, and a random instruction stream scored by an in-order transaction model.

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, mem_in_ready;
    logic [31:0] ex_pc, ex_result, ex_maddr;
    logic [7:0]  ex_mem_op;
    logic        ex_res_from_mem, ex_gr_we, ex_mem_req, ex_has_exception, ex_ertn, ex_rdcntid;
    logic [4:0]  ex_dest;
    logic [5:0]  ex_ecode;
    logic [8:0]  ex_esubcode;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        wb_in_ready, flush;
    logic        wb_valid;
    logic [31:0] wb_pc, wb_result, wb_maddr, wb_rdata;
    logic [7:0]  wb_mem_op;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [4:0]  wb_dest;
    logic        wb_res_from_mem, wb_gr_we, wb_has_exception, wb_ertn, wb_rdcntid;
    logic        mem_except_block, mem_fwd_we, mem_load_pending;
    logic [4:0]  mem_fwd_dest;
    logic [31:0] mem_fwd_data;

    always #5 clk = ~clk;

    mem_stage #(.DISCARD_W(2)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_in_ready(mem_in_ready),
        .ex_pc(ex_pc), .ex_result(ex_result), .ex_mem_op(ex_mem_op),
        .ex_res_from_mem(ex_res_from_mem), .ex_gr_we(ex_gr_we), .ex_dest(ex_dest),
        .ex_mem_req(ex_mem_req), .ex_has_exception(ex_has_exception), .ex_ecode(ex_ecode),
        .ex_esubcode(ex_esubcode), .ex_maddr(ex_maddr), .ex_ertn(ex_ertn), .ex_rdcntid(ex_rdcntid),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .wb_in_ready(wb_in_ready), .flush(flush), .wb_valid(wb_valid),
        .wb_pc(wb_pc), .wb_result(wb_result), .wb_maddr(wb_maddr), .wb_mem_op(wb_mem_op),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_dest(wb_dest),
        .wb_res_from_mem(wb_res_from_mem), .wb_gr_we(wb_gr_we),
        .wb_has_exception(wb_has_exception), .wb_ertn(wb_ertn), .wb_rdcntid(wb_rdcntid),
        .wb_rdata(wb_rdata), .mem_except_block(mem_except_block), .mem_fwd_we(mem_fwd_we),
        .mem_fwd_dest(mem_fwd_dest), .mem_fwd_data(mem_fwd_data),
        .mem_load_pending(mem_load_pending)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid   = 1'b0;
        ex_mem_req = 1'b0;
    endtask

    task automatic idle_inputs();
        clear_ex();
        ex_pc = '0; ex_result = '0; ex_maddr = '0; ex_mem_op = '0; ex_res_from_mem = 1'b0;
        ex_gr_we = 1'b0; ex_dest = '0; ex_has_exception = 1'b0; ex_ecode = '0;
        ex_esubcode = '0; ex_ertn = 1'b0; ex_rdcntid = 1'b0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; flush = 1'b0; wb_in_ready = 1'b1;
    endtask

    task automatic drive_ex(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                            input logic ld, input logic gr_we, input logic exc, input logic ertn);
        ex_valid = 1'b1; ex_pc = pc; ex_result = res; ex_maddr = res;
        ex_mem_op = ld ? 8'h04 : 8'h00; ex_res_from_mem = ld; ex_mem_req = ld;
        ex_gr_we = gr_we; ex_dest = dest; ex_has_exception = exc;
        ex_ecode = exc ? 6'h0a : 6'h00; ex_esubcode = '0; ex_ertn = ertn; ex_rdcntid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] result;
        logic [4:0]  dest;
        logic        gr_we, exc, ertn, ld;
        logic        exp_we, exp_blk, exp_pend;
    } vec_t;
    vec_t vecs [6];

    // random-stream model: instructions by id, in-order owed responses, in-order deliveries
    localparam int NID = 1200;
    logic [31:0] t_pc [NID], t_res [NID], t_data [NID];
    logic [4:0]  t_dest [NID];
    logic [7:0]  t_op [NID];
    logic        t_ld [NID], t_exc [NID], t_gw [NID];
    bit          accepted [NID], killed [NID];
    int          q_exp [$];
    int          q_resp [$];
    int          cur, nid, stall, id, h;
    bit          drain, xfer, mir;

    initial begin
        idle_inputs();
        rst = 1'b0;
        step(); step();
        chk("rst_mem_in_ready", 32'(mem_in_ready), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_fwd_we", 32'(mem_fwd_we), 0);
        chk("rst_except_block", 32'(mem_except_block), 0);
        chk("rst_load_pending", 32'(mem_load_pending), 0);
        chk("rst_wb_pc", wb_pc, 0);
        rst = 1'b1;
        step();
        chk("idle_mem_in_ready", 32'(mem_in_ready), 1);

        // LW answered in its first MEM cycle
        drive_ex(32'h1c000010, 32'h80000004, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        clear_ex();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("lw_pend_on_dok", 32'(mem_load_pending), 0);
        step();
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        chk("lw_wb_valid", 32'(wb_valid), 1);
        chk("lw_wb_rdata", wb_rdata, 32'hDEADBEEF);
        chk("lw_wb_pc", wb_pc, 32'h1c000010);
        chk("lw_wb_result", wb_result, 32'h80000004);
        chk("lw_wb_rfm", 32'(wb_res_from_mem), 1);
        step();
        chk("lw_wb_drained", 32'(wb_valid), 0);

        // load whose response is 3 cycles late
        drive_ex(32'h1c000020, 32'h80000010, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        clear_ex();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("late_in_ready_%0d", i), 32'(mem_in_ready), 0);
            chk($sformatf("late_pending_%0d", i), 32'(mem_load_pending), 1);
            step();
        end
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BADF00D;
        @(negedge clk);
        chk("late_wb_before", 32'(wb_valid), 0);
        step();
        data_sram_data_ok = 1'b0;
        chk("late_wb_valid", 32'(wb_valid), 1);
        chk("late_wb_rdata", wb_rdata, 32'h0BADF00D);
        step();

        // response captured while WB stalls, delivered later from the buffer
        drive_ex(32'h1c000030, 32'h80000020, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        clear_ex();
        wb_in_ready = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h12345678;
        step();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'hFFFF0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("have_pending_%0d", i), 32'(mem_load_pending), 0);
            chk($sformatf("have_wb_valid_%0d", i), 32'(wb_valid), 0);
            chk($sformatf("have_in_ready_%0d", i), 32'(mem_in_ready), 0);
            step();
        end
        wb_in_ready = 1'b1;
        @(negedge clk);
        chk("have_in_ready_go", 32'(mem_in_ready), 1);
        step();
        chk("have_wb_valid", 32'(wb_valid), 1);
        chk("have_wb_rdata", wb_rdata, 32'h12345678);
        step();

        // flush with MEM waiting and EX owing a response: two responses must be dropped
        drive_ex(32'h1c000040, 32'h80000030, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive_ex(32'h1c000044, 32'h80000034, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_wb_valid", 32'(wb_valid), 0);
        chk("flush_pending", 32'(mem_load_pending), 0);
        drive_ex(32'h1c000048, 32'h80000038, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        clear_ex();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA0000;
        @(negedge clk);
        chk("drop1_pending", 32'(mem_load_pending), 1);
        step();
        chk("drop1_wb_valid", 32'(wb_valid), 0);
        data_sram_rdata = 32'hBBBB0000;
        @(negedge clk);
        chk("drop2_pending", 32'(mem_load_pending), 1);
        step();
        chk("drop2_wb_valid", 32'(wb_valid), 0);
        data_sram_rdata = 32'hCCCC0000;
        step();
        data_sram_data_ok = 1'b0;
        chk("own_wb_valid", 32'(wb_valid), 1);
        chk("own_wb_rdata", wb_rdata, 32'hCCCC0000);
        chk("own_wb_pc", wb_pc, 32'h1c000048);
        step();

        // forwarding / exception-block vectors
        vecs[0] = '{32'h00000055, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'h00000055, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h00000000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h80000004, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFFFFFF, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h00001234, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int v = 0; v < 6; v++) begin
            drive_ex(32'h1c000100 + 32'(v * 4), vecs[v].result, vecs[v].dest, vecs[v].ld,
                     vecs[v].gr_we, vecs[v].exc, vecs[v].ertn);
            wb_in_ready = 1'b0;
            step();
            clear_ex();
            @(negedge clk);
            chk($sformatf("v%0d_fwd_we", v), 32'(mem_fwd_we), 32'(vecs[v].exp_we));
            chk($sformatf("v%0d_fwd_dest", v), 32'(mem_fwd_dest), 32'(vecs[v].dest));
            chk($sformatf("v%0d_fwd_data", v), mem_fwd_data, vecs[v].result);
            chk($sformatf("v%0d_blk_mem", v), 32'(mem_except_block), 32'(vecs[v].exp_blk));
            chk($sformatf("v%0d_pending", v), 32'(mem_load_pending), 32'(vecs[v].exp_pend));
            wb_in_ready = 1'b1;
            data_sram_data_ok = vecs[v].ld;
            step();
            data_sram_data_ok = 1'b0;
            chk($sformatf("v%0d_wb_valid", v), 32'(wb_valid), 1);
            chk($sformatf("v%0d_blk_wb", v), 32'(mem_except_block), 32'(vecs[v].exp_blk));
            step();
        end

        // synchronous reset while a load waits; stray response afterwards is ignored
        drive_ex(32'h1c000200, 32'h1234ABCD, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        clear_ex();
        step();
        rst = 1'b0;
        step();
        chk("rstw_in_ready", 32'(mem_in_ready), 0);
        chk("rstw_wb_valid", 32'(wb_valid), 0);
        chk("rstw_pending", 32'(mem_load_pending), 0);
        chk("rstw_fwd_we", 32'(mem_fwd_we), 0);
        chk("rstw_fwd_dest", 32'(mem_fwd_dest), 0);
        chk("rstw_fwd_data", mem_fwd_data, 0);
        chk("rstw_blk", 32'(mem_except_block), 0);
        chk("rstw_wb_pc", wb_pc, 0);
        chk("rstw_wb_rdata", wb_rdata, 0);
        rst = 1'b1;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h00000099;
        step();
        data_sram_data_ok = 1'b0;
        chk("stray_wb_valid", 32'(wb_valid), 0);
        chk("stray_in_ready", 32'(mem_in_ready), 1);
        // reset also forgets responses that were queued for discard
        drive_ex(32'h1c000210, 32'h80000100, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        clear_ex();
        flush = 1'b1;
        step();
        flush = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        drive_ex(32'h1c000220, 32'h80000104, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        clear_ex();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h00004444;
        step();
        data_sram_data_ok = 1'b0;
        chk("rstd_wb_valid", 32'(wb_valid), 1);
        chk("rstd_wb_rdata", wb_rdata, 32'h00004444);
        step();

        // random instruction stream against the transaction model
        cur = -1; nid = 0; stall = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            drain = (cyc >= 800);
            if (cur < 0 && !drain && nid < NID && $urandom_range(0, 9) < 7) begin
                id = nid; nid++;
                t_ld[id]  = (q_resp.size() <= 1) && ($urandom_range(0, 1) == 1);
                t_pc[id]  = $urandom; t_res[id] = $urandom; t_dest[id] = 5'($urandom);
                t_gw[id]  = 1'($urandom);
                t_exc[id] = !t_ld[id] && ($urandom_range(0, 9) == 0);
                t_op[id]  = t_ld[id] ? 8'(1 << $urandom_range(0, 4)) : 8'h00;
                accepted[id] = 1'b0; killed[id] = 1'b0;
                if (t_ld[id]) q_resp.push_back(id);
                cur = id;
            end
            if (cur >= 0) begin
                ex_valid = 1'b1; ex_pc = t_pc[cur]; ex_result = t_res[cur]; ex_maddr = t_res[cur];
                ex_mem_op = t_op[cur]; ex_res_from_mem = t_ld[cur]; ex_mem_req = t_ld[cur];
                ex_gr_we = t_gw[cur]; ex_dest = t_dest[cur]; ex_has_exception = t_exc[cur];
                ex_ertn = 1'b0;
            end else begin
                clear_ex();
            end
            wb_in_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            flush = !drain && ($urandom_range(0, 24) == 0);
            data_sram_data_ok = (q_resp.size() > 0) && (accepted[q_resp[0]] || killed[q_resp[0]])
                                && ($urandom_range(0, 1) == 1);
            data_sram_rdata = $urandom;

            @(negedge clk);
            mir  = mem_in_ready;
            xfer = wb_valid && wb_in_ready;
            if (xfer) begin
                if (q_exp.size() == 0) begin
                    chk("rnd_wb_unexpected", 32'(wb_valid), 0);
                end else begin
                    id = q_exp.pop_front();
                    chk($sformatf("rnd_pc_id%0d", id), wb_pc, t_pc[id]);
                    chk($sformatf("rnd_result_id%0d", id), wb_result, t_res[id]);
                    chk($sformatf("rnd_misc_id%0d", id),
                        32'({wb_dest, wb_gr_we, wb_res_from_mem, wb_has_exception, wb_mem_op}),
                        32'({t_dest[id], t_gw[id], t_ld[id], t_exc[id], t_op[id]}));
                    if (t_ld[id])
                        chk($sformatf("rnd_rdata_id%0d", id), wb_rdata, t_data[id]);
                end
            end
            if (data_sram_data_ok) begin
                h = q_resp.pop_front();
                t_data[h] = data_sram_rdata;
            end
            if (flush) begin
                foreach (q_exp[k]) killed[q_exp[k]] = 1'b1;
                q_exp.delete();
                if (cur >= 0) killed[cur] = 1'b1;
                cur = -1;
            end else if (cur >= 0 && mir) begin
                q_exp.push_back(cur);
                accepted[cur] = 1'b1;
                cur = -1;
            end
            if (q_exp.size() > 0 && !xfer) stall++;
            else stall = 0;
            if (stall == 200) chk("rnd_progress_timeout", 32'(q_exp.size()), 0);
            @(posedge clk);
            #1;
        end
        chk("rnd_drain_exp", 32'(q_exp.size()), 0);
        chk("rnd_drain_resp", 32'(q_resp.size()), 0);
        chk("rnd_ex_stuck", 32'(cur), 32'hFFFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
